// File: rtl/dtpu_launcher.sv
// Accelerator job launcher: writes a block of CSR bytes into a BRAM, runs the
// ap_start/ap_ready/ap_done/ap_continue handshake, then reports the result.
module dtpu_launcher #(
    parameter int unsigned DATA_WIDTH_CSR   = 8,
    parameter int unsigned ADDRESS_SIZE_CSR = 32,
    parameter int unsigned N_CFG            = 4,
    parameter int unsigned TIMEOUT_CYCLES   = 65535
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                cmd_valid,
    output logic                                cmd_ready,
    input  logic [ADDRESS_SIZE_CSR-1:0]         cmd_csr_addr,
    input  logic [N_CFG*DATA_WIDTH_CSR-1:0]     cmd_cfg,
    output logic                                csr_ce,
    output logic                                csr_we,
    output logic [ADDRESS_SIZE_CSR-1:0]         csr_address,
    output logic [DATA_WIDTH_CSR-1:0]           csr_din,
    output logic                                ap_start,
    output logic                                ap_continue,
    input  logic                                ap_ready,
    input  logic                                ap_done,
    input  logic                                ap_idle,
    output logic                                resp_valid,
    input  logic                                resp_ready,
    output logic                                resp_timeout,
    output logic [15:0]                         resp_cycles,
    output logic [15:0]                         jobs_done
);

    localparam int unsigned CFG_W    = N_CFG * DATA_WIDTH_CSR;
    localparam logic [4:0]  IDX_LAST = 5'(N_CFG - 1);

    typedef enum logic [2:0] {
        StIdle, StCfgWr, StWaitIdle, StStart, StRun, StAck, StResp
    } state_e;

    state_e                      state_q, state_d;
    logic [ADDRESS_SIZE_CSR-1:0] addr_q, addr_d;
    logic [CFG_W-1:0]            cfg_q, cfg_d;
    logic [4:0]                  idx_q, idx_d;
    logic [15:0]                 cnt_q, cnt_d;
    logic                        csr_en_q, csr_en_d;
    logic [ADDRESS_SIZE_CSR-1:0] csr_address_q, csr_address_d;
    logic [DATA_WIDTH_CSR-1:0]   csr_din_q, csr_din_d;
    logic                        ap_start_q, ap_start_d;
    logic                        ap_continue_q, ap_continue_d;
    logic                        resp_valid_q, resp_valid_d;
    logic                        resp_timeout_q, resp_timeout_d;
    logic [15:0]                 resp_cycles_q, resp_cycles_d;
    logic [15:0]                 jobs_done_q, jobs_done_d;

    logic [4:0]       idx_nxt;
    logic [16:0]      cnt_inc;
    logic [15:0]      cnt_sat;
    logic             timeout_hit;
    logic             done_hit;
    logic [CFG_W-1:0] cfg_shift;

    always_comb begin
        idx_nxt     = idx_q + 5'd1;
        cnt_inc     = {1'b0, cnt_q} + 17'd1;
        cnt_sat     = cnt_inc[16] ? 16'hFFFF : cnt_inc[15:0];
        timeout_hit = (32'(cnt_inc) >= TIMEOUT_CYCLES);
        // ap_done only counts in START when the same cycle also carries ap_ready
        done_hit    = ap_done && ((state_q == StRun) || ap_ready);
        cfg_shift   = cfg_q >> (32'(idx_nxt) * DATA_WIDTH_CSR);
    end

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        cfg_d          = cfg_q;
        idx_d          = idx_q;
        cnt_d          = cnt_q;
        csr_address_d  = csr_address_q;
        csr_din_d      = csr_din_q;
        resp_timeout_d = resp_timeout_q;
        resp_cycles_d  = resp_cycles_q;
        jobs_done_d    = jobs_done_q;

        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    addr_d        = cmd_csr_addr;
                    cfg_d         = cmd_cfg;
                    idx_d         = 5'd0;
                    csr_address_d = cmd_csr_addr;
                    csr_din_d     = cmd_cfg[DATA_WIDTH_CSR-1:0];
                    state_d       = StCfgWr;
                end
            end
            StCfgWr: begin
                if (idx_q == IDX_LAST) begin
                    state_d = StWaitIdle;
                end else begin
                    idx_d         = idx_nxt;
                    csr_address_d = addr_q + ADDRESS_SIZE_CSR'(idx_nxt);
                    csr_din_d     = cfg_shift[DATA_WIDTH_CSR-1:0];
                end
            end
            StWaitIdle: begin
                cnt_d = 16'd0;
                if (ap_idle) begin
                    state_d = StStart;
                end
            end
            StStart, StRun: begin
                cnt_d = cnt_sat;
                if (done_hit) begin
                    resp_cycles_d  = cnt_sat;
                    resp_timeout_d = 1'b0;
                    jobs_done_d    = jobs_done_q + 16'd1;
                    state_d        = StAck;
                end else if (timeout_hit) begin
                    // Report how long the aborted job was allowed to run
                    resp_cycles_d  = cnt_sat;
                    resp_timeout_d = 1'b1;
                    state_d        = StResp;
                end else if ((state_q == StStart) && ap_ready) begin
                    state_d = StRun;
                end
            end
            StAck: begin
                state_d = StResp;
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are registered from the next state so they line up with it
        csr_en_d      = (state_d == StCfgWr);
        ap_start_d    = (state_d == StStart);
        ap_continue_d = (state_d == StAck);
        resp_valid_d  = (state_d == StResp);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            addr_q         <= '0;
            cfg_q          <= '0;
            idx_q          <= '0;
            cnt_q          <= '0;
            csr_en_q       <= 1'b0;
            csr_address_q  <= '0;
            csr_din_q      <= '0;
            ap_start_q     <= 1'b0;
            ap_continue_q  <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_timeout_q <= 1'b0;
            resp_cycles_q  <= '0;
            jobs_done_q    <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            cfg_q          <= cfg_d;
            idx_q          <= idx_d;
            cnt_q          <= cnt_d;
            csr_en_q       <= csr_en_d;
            csr_address_q  <= csr_address_d;
            csr_din_q      <= csr_din_d;
            ap_start_q     <= ap_start_d;
            ap_continue_q  <= ap_continue_d;
            resp_valid_q   <= resp_valid_d;
            resp_timeout_q <= resp_timeout_d;
            resp_cycles_q  <= resp_cycles_d;
            jobs_done_q    <= jobs_done_d;
        end
    end

    assign cmd_ready    = (state_q == StIdle);
    assign csr_ce       = csr_en_q;
    assign csr_we       = csr_en_q;
    assign csr_address  = csr_address_q;
    assign csr_din      = csr_din_q;
    assign ap_start     = ap_start_q;
    assign ap_continue  = ap_continue_q;
    assign resp_valid   = resp_valid_q;
    assign resp_timeout = resp_timeout_q;
    assign resp_cycles  = resp_cycles_q;
    assign jobs_done    = jobs_done_q;

endmodule

// File: tb/tb_dtpu_launcher.sv
// Directed-vector bench for dtpu_launcher: a per-job timeline model predicts
// every output on every cycle; literal checks pin the model to known results.
module tb_dtpu_launcher;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 32;
    localparam int T  = 20;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            cmd_valid, cmd_ready;
    logic [AW-1:0]   cmd_csr_addr;
    logic [N*DW-1:0] cmd_cfg;
    logic            csr_ce, csr_we;
    logic [AW-1:0]   csr_address;
    logic [DW-1:0]   csr_din;
    logic            ap_start, ap_continue, ap_ready, ap_done, ap_idle;
    logic            resp_valid, resp_ready, resp_timeout;
    logic [15:0]     resp_cycles, jobs_done;

    always #5 clk = ~clk;

    dtpu_launcher #(
        .DATA_WIDTH_CSR  (DW),
        .ADDRESS_SIZE_CSR(AW),
        .N_CFG           (N),
        .TIMEOUT_CYCLES  (T)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_csr_addr(cmd_csr_addr),
        .cmd_cfg     (cmd_cfg),
        .csr_ce      (csr_ce),
        .csr_we      (csr_we),
        .csr_address (csr_address),
        .csr_din     (csr_din),
        .ap_start    (ap_start),
        .ap_continue (ap_continue),
        .ap_ready    (ap_ready),
        .ap_done     (ap_done),
        .ap_idle     (ap_idle),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_timeout(resp_timeout),
        .resp_cycles (resp_cycles),
        .jobs_done   (jobs_done)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected outputs for the current cycle
    bit          chk_en = 0;
    logic        e_ready, e_ce, e_start, e_cont, e_rvalid, e_to;
    logic [31:0] e_addr;
    logic [7:0]  e_din;
    logic [15:0] e_cycles, e_jobs;
    bit          e_cyc_known;

    // Values carried over from the previous job
    logic [31:0] p_addr = 0;
    logic [7:0]  p_din = 0;
    logic [15:0] p_cycles = 0, p_jobs = 0;
    logic        p_to = 0;
    bit          p_cyc_known = 1;

    // Observations for the literal checks
    int          n_start, n_cont;
    logic [31:0] wr_addr[$];
    logic [7:0]  wr_data[$];
    logic [15:0] o_cycles, o_jobs;
    logic        o_to;

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmd_ready",    32'(cmd_ready),    32'(e_ready));
            check("csr_ce",       32'(csr_ce),       32'(e_ce));
            check("csr_we",       32'(csr_we),       32'(e_ce));
            check("csr_address",  csr_address,       e_addr);
            check("csr_din",      32'(csr_din),      32'(e_din));
            check("ap_start",     32'(ap_start),     32'(e_start));
            check("ap_continue",  32'(ap_continue),  32'(e_cont));
            check("resp_valid",   32'(resp_valid),   32'(e_rvalid));
            check("resp_timeout", 32'(resp_timeout), 32'(e_to));
            check("jobs_done",    32'(jobs_done),    32'(e_jobs));
            if (e_cyc_known) check("resp_cycles", 32'(resp_cycles), 32'(e_cycles));
            if (ap_start) n_start++;
            if (ap_continue) n_cont++;
            if (csr_we) begin
                wr_addr.push_back(csr_address);
                wr_data.push_back(csr_din);
            end
            if (resp_valid) begin
                o_cycles = resp_cycles;
                o_jobs   = jobs_done;
                o_to     = resp_timeout;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_cmd_ready"},    32'(cmd_ready),    32'd1);
        check({tag, "_csr_ce"},       32'(csr_ce),       32'd0);
        check({tag, "_csr_we"},       32'(csr_we),       32'd0);
        check({tag, "_csr_address"},  csr_address,       32'd0);
        check({tag, "_csr_din"},      32'(csr_din),      32'd0);
        check({tag, "_ap_start"},     32'(ap_start),     32'd0);
        check({tag, "_ap_continue"},  32'(ap_continue),  32'd0);
        check({tag, "_resp_valid"},   32'(resp_valid),   32'd0);
        check({tag, "_resp_timeout"}, 32'(resp_timeout), 32'd0);
        check({tag, "_resp_cycles"},  32'(resp_cycles),  32'd0);
        check({tag, "_jobs_done"},    32'(jobs_done),    32'd0);
    endtask

    // w: extra cycles ap_idle stays low; r: ap_ready offset into START (-1 never);
    // d: ap_done offset after ap_ready; s: resp_ready stall; abort_at: cycle to reset
    task automatic run_job(input logic [31:0] a, input logic [31:0] c, input int w,
                           input int r, input int d, input int s, input int abort_at);
        int          st_k, drel, rk, last_st, ackk, bi;
        bit          ok, aborted;
        logic [31:0] sh;
        st_k    = N + 2 + w;
        drel    = r + d;
        ok      = (r >= 0) && (drel <= T - 1);
        rk      = ok ? st_k + drel + 2 : st_k + T;
        ackk    = st_k + drel + 1;
        last_st = (r >= 0 && r <= T - 1) ? r : T - 1;
        aborted = 0;
        n_start = 0;
        n_cont  = 0;
        wr_addr.delete();
        wr_data.delete();
        cmd_valid    = 1'b1;
        cmd_csr_addr = a;
        cmd_cfg      = c;
        ap_idle      = 1'b0;
        ap_ready     = 1'b0;
        ap_done      = 1'b0;
        resp_ready   = 1'b0;
        for (int k = 1; k <= rk + s + 1 && !aborted; k++) begin
            @(posedge clk);
            #1;
            if (k == abort_at) begin
                chk_en    = 0;
                cmd_valid = 1'b0;
                ap_ready  = 1'b0;
                ap_done   = 1'b0;
                #1 reset = 1'b1;
                #1 check_all_zero("reset_mid_run");
                p_addr = 0; p_din = 0; p_cycles = 0; p_jobs = 0; p_to = 0; p_cyc_known = 1;
                aborted = 1;
            end else begin
                ap_idle      = (k >= N + 1 + w);
                ap_ready     = (r >= 0) && (k == st_k + r);
                // Stray ap_done pulses outside START/RUN must be ignored
                ap_done      = ((r >= 0) && (k == st_k + drel)) || k == 2 || k == N + 1 || k == rk;
                resp_ready   = (k >= rk + s);
                cmd_valid    = (k <= rk + s);
                cmd_csr_addr = ~a;
                cmd_cfg      = ~c;

                bi       = (k <= N) ? k - 1 : N - 1;
                sh       = c >> (8 * bi);
                e_ready  = (k > rk + s);
                e_ce     = (k <= N);
                e_addr   = a + 32'(bi);
                e_din    = sh[7:0];
                e_start  = (k >= st_k) && (k <= st_k + last_st);
                e_cont   = ok && (k == ackk);
                e_rvalid = (k >= rk) && (k <= rk + s);
                if (ok && k >= ackk) begin
                    e_jobs = p_jobs + 16'd1; e_to = 1'b0;
                    e_cycles = 16'(drel + 1); e_cyc_known = 1;
                end else if (!ok && k >= rk) begin
                    e_jobs = p_jobs; e_to = 1'b1;
                    e_cycles = p_cycles; e_cyc_known = 0;
                end else begin
                    e_jobs = p_jobs; e_to = p_to;
                    e_cycles = p_cycles; e_cyc_known = p_cyc_known;
                end
                chk_en = 1;
            end
        end
        if (!aborted) begin
            @(negedge clk);
            #1 chk_en = 0;
            cmd_valid = 1'b0;
            p_addr = e_addr; p_din = e_din; p_jobs = e_jobs; p_to = e_to;
            p_cycles = e_cycles; p_cyc_known = e_cyc_known;
        end
    endtask

    initial begin
        logic [31:0] lit_a[4];
        logic [7:0]  lit_d[4];
        lit_a = '{32'h10, 32'h11, 32'h12, 32'h13};
        lit_d = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        cmd_valid = 0; cmd_csr_addr = 0; cmd_cfg = 0;
        ap_ready = 0; ap_done = 0; ap_idle = 0; resp_ready = 0;

        #2 reset = 1'b1;
        #1 check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Basic job with a 5-cycle response stall
        run_job(32'h10, 32'hDDCCBBAA, 0, 3, 10, 5, -1);
        check("j1_n_start", 32'(n_start), 32'd4);
        check("j1_n_cont", 32'(n_cont), 32'd1);
        check("j1_cycles", 32'(o_cycles), 32'd14);
        check("j1_timeout", 32'(o_to), 32'd0);
        check("j1_jobs", 32'(o_jobs), 32'd1);
        check("j1_n_writes", 32'(wr_addr.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("j1_wr_addr", (i < wr_addr.size()) ? wr_addr[i] : 32'hFFFFFFFF, lit_a[i]);
            check("j1_wr_data", (i < wr_data.size()) ? 32'(wr_data[i]) : 32'hFFFFFFFF,
                  32'(lit_d[i]));
        end

        // ap_ready and ap_done together on the first START cycle
        run_job(32'h80, 32'h44332211, 2, 0, 0, 0, -1);
        check("j2_n_start", 32'(n_start), 32'd1);
        check("j2_n_cont", 32'(n_cont), 32'd1);
        check("j2_cycles", 32'(o_cycles), 32'd1);
        check("j2_jobs", 32'(o_jobs), 32'd2);

        // ap_ready never arrives: timeout from START
        run_job(32'h200, 32'h01020304, 0, -1, 0, 1, -1);
        check("j3_n_start", 32'(n_start), 32'd20);
        check("j3_n_cont", 32'(n_cont), 32'd0);
        check("j3_timeout", 32'(o_to), 32'd1);
        check("j3_jobs", 32'(o_jobs), 32'd2);

        // Address wraps around; success clears the earlier timeout flag
        run_job(32'hFFFFFFFE, 32'h5A5AA5A5, 1, 2, 16, 0, -1);
        check("j4_cycles", 32'(o_cycles), 32'd19);
        check("j4_timeout", 32'(o_to), 32'd0);
        check("j4_jobs", 32'(o_jobs), 32'd3);
        check("j4_last_addr", (wr_addr.size() == 4) ? wr_addr[3] : 32'hFFFFFFFF, 32'h1);

        // ap_done one cycle too late: timeout from RUN
        run_job(32'h300, 32'h12345678, 0, 5, 15, 2, -1);
        check("j5_n_start", 32'(n_start), 32'd6);
        check("j5_n_cont", 32'(n_cont), 32'd0);
        check("j5_timeout", 32'(o_to), 32'd1);
        check("j5_jobs", 32'(o_jobs), 32'd3);

        // ap_done on the very last allowed cycle still succeeds
        run_job(32'h310, 32'h9ABCDEF0, 0, 4, 15, 0, -1);
        check("j6_cycles", 32'(o_cycles), 32'd20);
        check("j6_timeout", 32'(o_to), 32'd0);
        check("j6_jobs", 32'(o_jobs), 32'd4);

        // Reset in RUN, then the first job again counted from zero
        run_job(32'h10, 32'hDDCCBBAA, 0, 3, 10, 5, 12);
        @(negedge clk);
        reset = 1'b0;
        run_job(32'h10, 32'hDDCCBBAA, 0, 3, 10, 5, -1);
        check("j7_n_start", 32'(n_start), 32'd4);
        check("j7_n_cont", 32'(n_cont), 32'd1);
        check("j7_cycles", 32'(o_cycles), 32'd14);
        check("j7_jobs", 32'(o_jobs), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dtpu_launcher.md
DTPU_LAUNCHER -- requirements
Module: dtpu_launcher

Interface
REQ-001 Parameter DATA_WIDTH_CSR, default 8, width of one CSR byte lane.
REQ-002 Parameter ADDRESS_SIZE_CSR, default 32, width of the CSR BRAM address.
REQ-003 Parameter N_CFG, default 4, number of CSR bytes written per job (range 1..16).
REQ-004 Parameter TIMEOUT_CYCLES, default 65535, maximum cycles waited in START plus RUN before abort.
REQ-005 clk  input  1  single clock; all logic is on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 cmd_valid  input  1  job request.
REQ-008 cmd_ready  output  1  launcher can accept a job; equals (state==IDLE).
REQ-009 cmd_csr_addr  input  ADDRESS_SIZE_CSR  first CSR address to write.
REQ-010 cmd_cfg  input  N_CFG*DATA_WIDTH_CSR  configuration bytes; byte 0 in the LSBs.
REQ-011 csr_ce, csr_we  output  1 each  CSR BRAM enable and write enable.
REQ-012 csr_address  output  ADDRESS_SIZE_CSR  CSR BRAM write address.
REQ-013 csr_din  output  DATA_WIDTH_CSR  CSR BRAM write data.
REQ-014 ap_start, ap_continue  output  1 each  initiator side of the accelerator handshake.
REQ-015 ap_ready, ap_done, ap_idle  input  1 each  responder side of the accelerator handshake.
REQ-016 resp_valid  output  1  job result available.
REQ-017 resp_ready  input  1  result consumed.
REQ-018 resp_timeout  output  1  job aborted by timeout.
REQ-019 resp_cycles  output  16  cycles from first ap_start high to ap_done observed, saturating at 16'hFFFF.
REQ-020 jobs_done  output  16  count of successful jobs, wraps 16'hFFFF -> 0.

Function
REQ-021 States: IDLE, CFG_WR, WAIT_IDLE, START, RUN, ACK, RESP; state is registered.
REQ-022 IDLE: on cmd_valid&cmd_ready, latch cmd_csr_addr and cmd_cfg, clear byte index, go to CFG_WR.
REQ-023 CFG_WR: one byte per cycle; csr_ce=csr_we=1, csr_address=latched_addr+i, csr_din=byte i; after byte N_CFG-1 go to WAIT_IDLE; N_CFG cycles total.
REQ-024 Outside CFG_WR, csr_ce=csr_we=0 and csr_address/csr_din hold their last value.
REQ-025 WAIT_IDLE: when ap_idle=1 go to START; ap_start stays 0 while waiting.
REQ-026 START: ap_start=1 on every cycle in this state; clear cycle counter on entry; when ap_ready=1 sampled, go to RUN (ap_start 0 from the next cycle).
REQ-027 START with ap_ready=1 and ap_done=1 in the same cycle: go directly to ACK.
REQ-028 RUN: ap_start=0; when ap_done=1 go to ACK, capturing resp_cycles.
REQ-029 ACK: ap_continue=1 for exactly one cycle, jobs_done increments, resp_timeout cleared, go to RESP.
REQ-030 Cycle counter increments every cycle in START and RUN, saturating at 16'hFFFF.
REQ-031 Timeout: if counter reaches TIMEOUT_CYCLES in START or RUN without ap_done, go to RESP with resp_timeout=1, ap_start=0, ap_continue not pulsed, jobs_done unchanged.
REQ-032 RESP: resp_valid=1; hold resp_timeout/resp_cycles stable until resp_valid&resp_ready, then go to IDLE.
REQ-033 cmd_valid outside IDLE is ignored; no command is queued.
REQ-034 ap_done seen outside START/RUN is ignored.
REQ-035 All outputs except cmd_ready are registered.

Reset
REQ-036 Reset asserted: state=IDLE, every registered output 0 (csr_*, ap_start, ap_continue, resp_valid, resp_timeout, resp_cycles, jobs_done).
REQ-037 Reset mid-job: ap_start and csr_we drop asynchronously, no ap_continue pulse, and the job is lost.
REQ-038 First cmd accepted on the first clk edge after reset deassert with cmd_valid=1.

Verification
REQ-039 N_CFG=4, addr=0x10, cfg=0xDDCCBBAA, ap_idle=1 -> writes AA@0x10, BB@0x11, CC@0x12, DD@0x13 on 4 consecutive cycles, then ap_start=1.
REQ-040 ap_ready 3 cycles after ap_start, ap_done 10 cycles later -> ap_start high 4 cycles, one ap_continue pulse, resp_valid with resp_cycles=14, resp_timeout=0, jobs_done=1.
REQ-041 ap_ready=ap_done=1 on the first START cycle -> next state ACK, resp_cycles=1, single ap_continue.
REQ-042 TIMEOUT_CYCLES=20, ap_ready never -> ap_start falls after 20 cycles, resp_timeout=1, no ap_continue, jobs_done unchanged.
REQ-043 resp_ready=0 for 5 cycles then 1 -> resp fields stable, cmd_ready=0 throughout, IDLE one cycle after handshake.
REQ-044 Reset pulse during RUN -> all outputs 0 immediately, next job behaves as REQ-039/040 with jobs_done counted from 0.
